// File: rtl/pc_sequencer_16.sv
// Program-counter register feeding an external half-adder-chain incrementer.
// Adds parallel load, IDLE/RUN/HALT sequencing, terminal-count halt and a sticky overflow flag.
module pc_sequencer_16 #(
  parameter int                RESET_VALUE_W = 16,
  parameter int                WIDTH         = 16,
  parameter logic [WIDTH-1:0]  RESET_VALUE   = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             stop,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic [WIDTH-1:0] limit,
  input  logic             limit_en,
  input  logic             clear_ovf,
  input  logic [WIDTH-1:0] inc_sum,
  input  logic             inc_carry,
  output logic [WIDTH-1:0] inc_a,
  output logic [WIDTH-1:0] pc,
  output logic             running,
  output logic             halted,
  output logic             at_limit,
  output logic             overflow
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] pc_next;
  logic             step;
  logic             limit_hit;

  assign inc_a = pc;

  always_comb begin
    step      = (state == RUN) && en && !load && !stop;
    // The terminal count is matched against the incrementer result, so a load never halts.
    limit_hit = step && limit_en && (inc_sum == limit);

    pc_next = pc;
    if (load)
      pc_next = load_value;
    else if (step)
      pc_next = inc_sum;

    state_next = state;
    case (state)
      IDLE:    if (start) state_next = RUN;
      RUN:     if (stop || limit_hit) state_next = HALT;
      HALT:    if (start) state_next = RUN;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc       <= RESET_VALUE;
      state    <= IDLE;
      running  <= 1'b0;
      halted   <= 1'b0;
      at_limit <= 1'b0;
      overflow <= 1'b0;
    end else begin
      pc       <= pc_next;
      state    <= state_next;
      running  <= (state_next == RUN);
      halted   <= (state_next == HALT);
      at_limit <= limit_en && (pc_next == limit);
      // A wrap on the same edge as a clear request leaves the flag set.
      if (step && inc_carry)
        overflow <= 1'b1;
      else if (clear_ovf)
        overflow <= 1'b0;
    end
  end

endmodule

// File: doc/pc_sequencer_16.md
Name: pc_sequencer_16

Overview:
- 16-bit program-counter register that sits directly upstream of the 16-bit half-adder-chain incrementer.
- It drives the incrementer's operand from its current count and registers the incrementer's sum and carry-out on each counting clock.
- It adds parallel load, a start/stop state machine, a programmable terminal count, and a sticky overflow flag.
- It is the sequencing stage for the lab datapath: downstream logic reads `pc` as the current address.

Parameters:
- RESET_VALUE, 16'h0000, value loaded into `pc` on reset.
- WIDTH, 16, counter width; it must match the incrementer. Only 16 is supported.

Ports:
- `clk`  input  1  system clock; all state updates on its rising edge.
- `rst_n`  input  1  asynchronous active-low reset.
- `start`  input  1  pulse: leave IDLE/HALT and begin counting.
- `stop`  input  1  pulse: enter HALT from RUN.
- `en`  input  1  count enable; meaningful only in RUN.
- `load`  input  1  synchronous parallel load request.
- `load_value`  input  16  value written to `pc` on load.
- `limit`  input  16  terminal count.
- `limit_en`  input  1  1 = halt automatically when `pc` reaches `limit`.
- `clear_ovf`  input  1  synchronous clear of `overflow`.
- `inc_sum`  input  16  sum from the incrementer (expected `pc`+1).
- `inc_carry`  input  1  final carry from the incrementer.
- `inc_a`  output  16  operand to the incrementer; combinationally equal to `pc`.
- `pc`  output  16  current count (registered).
- `running`  output  1  1 while the FSM is in RUN.
- `halted`  output  1  1 while the FSM is in HALT.
- `at_limit`  output  1  registered; 1 when `pc` equals `limit` and `limit_en` is 1.
- `overflow`  output  1  sticky; set when a counting step wraps FFFF to 0000.

Behaviour:
- **Reset (`rst_n`=0, asynchronous):**
  - `pc`=RESET_VALUE; FSM=IDLE.
  - `running`=0, `halted`=0, `at_limit`=0, `overflow`=0.
  - `inc_a` follows `pc`.
  - Reset mid-count aborts immediately, with no partial update. Release is sampled on the next rising edge.
- **FSM states:** IDLE, RUN, HALT. `running`=(state==RUN); `halted`=(state==HALT); both are registered outputs.
  - **IDLE:** `start`=1 → RUN. Otherwise stay.
  - **RUN:**
    - `stop`=1 → HALT.
    - Else if a step occurs this cycle with `limit_en`=1 and `inc_sum`==`limit` → HALT (the step still commits).
    - Otherwise stay.
  - **HALT:** `start`=1 → RUN. Otherwise stay.
  - `start` and `stop` asserted together: `stop` wins in RUN; `start` wins in IDLE/HALT.
- **Counting step:**
  - Occurs when state==RUN, `en`=1, `load`=0 and `stop`=0.
  - On the edge: `pc` ← `inc_sum`. If `inc_carry`=1, `overflow` ← 1.
  - Latency: `pc` shows the incremented value 1 cycle after `en` is sampled; one increment per cycle.
  - The incrementer path is purely combinational.
- **Load:**
  - `load`=1 writes `load_value` into `pc` in any state, including IDLE and HALT.
  - Load has priority over a step in the same cycle; no increment occurs that cycle.
  - Load does not change FSM state and does not touch `overflow`.
- **Hold:** in IDLE and HALT, or in RUN with `en`=0, `pc` holds.
- **Wrap-around:** a step from FFFF yields 0000 with `inc_carry`=1, so `overflow` is set. `pc` keeps counting; there is no saturation.
- **`overflow`:**
  - Cleared only by reset or `clear_ovf`=1.
  - If `clear_ovf` and a set condition occur in the same cycle, the set wins (`overflow`=1).
- **`at_limit`:** registered every cycle as (next `pc` == `limit`) && `limit_en`; it reflects the `pc` value visible in the same cycle.
- **Limit matching:**
  - Compares `inc_sum`, not the loaded value. Loading `pc`=`limit` sets `at_limit` but does not halt.
  - A `limit` of 0000 with `limit_en`=1 halts on the wrap step, which also sets `overflow`.
- **Consistency:** `inc_sum` and `inc_carry` are trusted. No internal adder duplicates the incrementer.

Test Plan:
1. Reset then `start`, `en`=1 for 5 cycles from RESET_VALUE 0000 → `pc` steps 0001..0005 one per cycle; `running`=1; `overflow`=0.
2. `load`=1, `load_value`=FFFE while `en`=1 in RUN → next `pc`=FFFE (no increment). Two more steps → FFFF, then 0000 with `overflow`=1. `clear_ovf` → 0.
3. `limit_en`=1, `limit`=0010, `load` 000E, run → `pc`=000F, then 0010 with `at_limit`=1 and `halted`=1. Further `en` → `pc` stays 0010. `start` → resumes to 0011.
4. RUN with `start`+`stop` same cycle → HALT. In HALT, `start`+`stop` → RUN. `stop` with `en`=1 → no increment that cycle.
5. Assert `rst_n`=0 asynchronously mid-cycle at `pc`=1234, `overflow`=1 → outputs go to 0000/IDLE/0 immediately, before the next `clk` edge.
6. `clear_ovf`=1 on the same edge as a wrap step FFFF→0000 → `overflow`=1 afterwards.
